// File: rtl/draw_pkg.sv
// Shared definitions for the sprite drawing blocks: ROM code meanings,
// default visible-area sizes and the fixed hcount/vcount-to-pixel latency.
package draw_pkg;

  typedef enum logic [1:0] {
    CODE_TRANSP = 2'b00,
    CODE_A      = 2'b01,
    CODE_B      = 2'b10,
    CODE_WHITE  = 2'b11
  } code_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  // Cycles from hcount/vcount presentation to pixel/opaque; the timing
  // generator delays its syncs by the same amount.
  localparam int DRAW_LAT = 3;

endpackage

// File: rtl/block_rom.sv
// Synchronous sprite ROM holding one BPP-bit code per sprite pixel, row-major.
// Contents are supplied from MEM_INIT through the implementation flow's memory
// initialisation; the read data register is deliberately left without reset.
module block_rom #(
  parameter int ADDR_W   = 12,
  parameter int BPP      = 2,
  parameter int DEPTH    = 53 * 54,
  parameter     MEM_INIT = "block.mem"
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [BPP-1:0]    o_data
);

  logic [BPP-1:0] r_mem [0:DEPTH-1];

  // Reject configurations whose address space cannot cover the sprite or that
  // give the ROM no content source.
  if ((1 << ADDR_W) < DEPTH) begin : g_addrTooNarrow
    $error("block_rom: ADDR_W too narrow for DEPTH");
  end
  if (MEM_INIT == '0) begin : g_noInitFile
    $error("block_rom: MEM_INIT must name a content file");
  end

  // One-cycle registered read.
  always_ff @(posedge i_clk) begin
    o_data <= r_mem[i_addr];
  end

endmodule

// File: rtl/draw_block_sprite.sv
// Draws one W x H ROM sprite at a frame-latched (x, y) position with edge
// clipping, two selectable colours, white and transparent codes.
// Pipeline: stage 0 hit/address, stage 1 ROM read, stage 2 palette output.
module draw_block_sprite
  import draw_pkg::*;
#(
  parameter int W        = 53,
  parameter int H        = 54,
  parameter int ADDR_W   = 12,
  parameter int BPP      = 2,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter     MEM_INIT = "block.mem"
) (
  input  logic        vclk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [10:0] x_pos,
  input  logic [9:0]  y_pos,
  input  logic        enable,
  input  logic [7:0]  color_a,
  input  logic [7:0]  color_b,
  output logic [7:0]  pixel,
  output logic        opaque
);

  if (BPP != 2) begin : g_badBpp
    $error("draw_block_sprite: only BPP=2 is supported");
  end

  logic [10:0]       r_xPos;
  logic [9:0]        r_yPos;
  logic              r_en;
  logic [ADDR_W-1:0] r_rowBase;
  logic [ADDR_W-1:0] r_addr;
  logic              r_v0;
  logic              r_v1;

  logic [11:0]       w_h12;
  logic [11:0]       w_v12;
  logic [11:0]       w_xLeft;
  logic [11:0]       w_xRight;
  logic [11:0]       w_yTop;
  logic [11:0]       w_yBottom;
  logic              w_hInSprite;
  logic              w_vInSprite;
  logic              w_hit;
  logic              w_lastCol;
  logic              w_frameStart;
  logic [ADDR_W-1:0] w_col;
  logic [ADDR_W-1:0] w_addr;
  logic [BPP-1:0]    w_code;
  logic [7:0]        w_pixelNext;
  logic              w_opaqueNext;

  // 12-bit bounds so that x + W and y + H never wrap.
  assign w_h12     = {1'b0, hcount};
  assign w_v12     = {2'b00, vcount};
  assign w_xLeft   = {1'b0, r_xPos};
  assign w_xRight  = w_xLeft + 12'(W);
  assign w_yTop    = {2'b00, r_yPos};
  assign w_yBottom = w_yTop + 12'(H);

  assign w_frameStart = (hcount == 11'd0) && (vcount == 10'd0);
  assign w_hInSprite  = (w_h12 >= w_xLeft) && (w_h12 < w_xRight);
  assign w_vInSprite  = (w_v12 >= w_yTop) && (w_v12 < w_yBottom) &&
                        (w_v12 < 12'(V_ACTIVE));
  assign w_hit        = r_en && w_hInSprite && w_vInSprite &&
                        (w_h12 < 12'(H_ACTIVE));

  // Last sprite column of a visible line; also fires past the right screen
  // edge so a clipped sprite keeps its row base in step.
  assign w_lastCol = r_en && w_vInSprite && (w_h12 == (w_xRight - 12'd1));

  // Address = start of current sprite row + column, so no multiplier is needed.
  assign w_col  = ADDR_W'(w_h12 - w_xLeft);
  assign w_addr = r_rowBase + w_col;

  // Frame-latched position/enable, row base tracking and stage-0 valid.
  always_ff @(posedge vclk) begin
    if (rst) begin
      r_xPos    <= '0;
      r_yPos    <= '0;
      r_en      <= 1'b0;
      r_rowBase <= '0;
      r_v0      <= 1'b0;
    end else begin
      if (w_frameStart) begin
        r_xPos    <= x_pos;
        r_yPos    <= y_pos;
        r_en      <= enable;
        r_rowBase <= '0;
      end else if (w_lastCol) begin
        r_rowBase <= r_rowBase + ADDR_W'(W);
      end
      r_v0 <= w_hit;
    end
  end

  // Stage-0 ROM address register; pure datapath, qualified by r_v0.
  always_ff @(posedge vclk) begin
    r_addr <= w_addr;
  end

  block_rom #(
    .ADDR_W  (ADDR_W),
    .BPP     (BPP),
    .DEPTH   (W * H),
    .MEM_INIT(MEM_INIT)
  ) u_rom (
    .i_clk (vclk),
    .i_addr(r_addr),
    .o_data(w_code)
  );

  // Valid bit travelling alongside the ROM read.
  always_ff @(posedge vclk) begin
    if (rst) begin
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= r_v0;
    end
  end

  // Palette lookup; colours are taken live so changes show on the next pixel.
  always_comb begin
    w_pixelNext  = 8'h00;
    w_opaqueNext = 1'b0;
    if (r_v1) begin
      case (code_t'(w_code))
        CODE_A: begin
          w_pixelNext  = color_a;
          w_opaqueNext = 1'b1;
        end
        CODE_B: begin
          w_pixelNext  = color_b;
          w_opaqueNext = 1'b1;
        end
        CODE_WHITE: begin
          w_pixelNext  = 8'hFF;
          w_opaqueNext = 1'b1;
        end
        default: begin
          w_pixelNext  = 8'h00;
          w_opaqueNext = 1'b0;
        end
      endcase
    end
  end

  // Registered output stage.
  always_ff @(posedge vclk) begin
    if (rst) begin
      pixel  <= 8'h00;
      opaque <= 1'b0;
    end else begin
      pixel  <= w_pixelNext;
      opaque <= w_opaqueNext;
    end
  end

endmodule

// File: doc/draw_block_sprite.md
Name: draw_block_sprite

Overview:
- Parametrised successor to the fixed-position tetromino block drawers.
- Renders one W x H sprite, stored as BPP-bit codes in a synchronous ROM, at a runtime-movable (x, y) position.
- Adds per-instance colour selection, transparency flag, screen-edge clipping and a fixed, documented pipeline latency.
- Sits between the VGA timing generator (hcount/vcount) and the pixel mux; one instance per on-screen block.

Parameters:
- W, 53, sprite width in pixels
- H, 54, sprite height in lines
- ADDR_W, 12, ROM address width; must satisfy 2^ADDR_W >= W*H
- BPP, 2, bits per ROM code; only 2 supported in this generation
- H_ACTIVE, 640, visible pixels per line; no hit at hcount >= H_ACTIVE
- V_ACTIVE, 480, visible lines; no hit at vcount >= V_ACTIVE
- MEM_INIT, "block.mem", ROM init file passed to sub-module

Ports:
- vclk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- hcount  in  11  current horizontal pixel count
- vcount  in  10  current line count
- x_pos  in  11  sprite left edge, sampled at frame start
- y_pos  in  10  sprite top line, sampled at frame start
- enable  in  1  sprite visible this frame, sampled at frame start
- color_a  in  8  RGB332 colour for code 01
- color_b  in  8  RGB332 colour for code 10
- pixel  out  8  RGB332 output pixel
- opaque  out  1  1 = pixel is sprite content; 0 = transparent, mux shows background

Behaviour:
- Clock and reset: one clock, vclk. Reset is synchronous and active-high on rst; it is sampled only on the vclk rising edge.
- Reset values: pixel=0, opaque=0, x_r=0, y_r=0, en_r=0, row_base=0, all pipeline valid bits=0.
- Frame start (hcount==0 && vcount==0):
  - latch x_r<=x_pos, y_r<=y_pos, en_r<=enable; row_base<=0.
  - Mid-frame position changes never tear the sprite.
- Stage 0 (hit/address, registered):
  - hit = en_r && hcount in [x_r, x_r+W) && vcount in [y_r, y_r+H) && hcount<H_ACTIVE && vcount<V_ACTIVE.
  - Comparisons use 12-bit sums so x_r+W cannot wrap.
  - col = hcount - x_r; addr = row_base + col, ADDR_W bits; no multiplier.
  - When hit && col==W-1: row_base <= row_base + W.
  - A sprite clipped at the right edge still advances row_base: the advance also fires at hcount==x_r+W-1 when that is >= H_ACTIVE and the line is in range.
  - v0 <= hit.
- Stage 1 (ROM): block_rom returns code[BPP-1:0] one cycle after addr. v1 <= v0.
- Stage 2 (palette, registered output) when v1:
  - 00 -> pixel=8'h00, opaque=0
  - 01 -> pixel=color_a, opaque=1
  - 10 -> pixel=color_b, opaque=1
  - 11 -> pixel=8'hFF, opaque=1
  - When !v1: pixel=8'h00, opaque=0.
- Latency: exactly 3 vclk cycles from hcount/vcount presentation to pixel/opaque. The timing generator delays its sync outputs by 3 to match.
- color_a/color_b are sampled in stage 2; changes take effect on the next pixel, with no frame latch.
- Boundary cases:
  - x_pos >= H_ACTIVE or y_pos >= V_ACTIVE -> sprite fully off-screen; no opaque pixels.
  - y_r+H > V_ACTIVE -> bottom rows clipped.
  - enable falling mid-frame -> no effect until the next frame start.
  - rst mid-line -> outputs 0 on the next cycle. Nothing is drawn until after the next frame start, since en_r=0.
- No state machine beyond the pipeline valid bits and frame-latched registers. All sequential logic uses non-blocking assignment.

Decomposition:
- Shared package/header draw_pkg holds:
  - code constants CODE_TRANSP=2'b00, CODE_A=2'b01, CODE_B=2'b10, CODE_WHITE=2'b11
  - H_ACTIVE/V_ACTIVE defaults
  - the latency constant DRAW_LAT=3
- Sub-module block_rom (params ADDR_W, BPP, DEPTH=W*H, MEM_INIT): synchronous read, 1-cycle latency, no reset on data.

Test Plan:
- Reset: rst=1 for 4 cycles, with hcount/vcount sweeping inside the sprite area -> pixel=0, opaque=0 throughout and for 3 cycles after release.
- Basic draw:
  - Stimulus: x_pos=208, y_pos=407, enable=1; ROM word0=11, word1=01, color_a=8'hE0.
  - Response: at (208,407) pixel=FF opaque=1 appears 3 cycles later; (209,407) gives E0.
  - (207,407) and (261,407) give opaque=0.
- Row addressing: ROM addr 53 = 10, color_b=8'h1C -> (208,408) gives 1C, proving row_base=W. Last pixel (260,460) reads addr 2861.
- Frame latch: change x_pos 208->300 at vcount=430 -> rest of the frame still at 208; next frame at 300.
- Right clip: x_pos=620 -> opaque only for hcount 620..639. Line 408 reads addr 53 at hcount 620.
- Transparency/enable:
  - code 00 cells give opaque=0, pixel=00.
  - enable=0 at frame start gives no opaque pixel in the whole frame.
